// File: rtl/gray_decoder_pkg.sv
// Shared types and helpers for the Gray-code position decoder.
// Holds the tracker state encoding and a width-generic Gray-to-binary conversion.
package gray_pkg;

    // A stray 2'b11 is treated as UNSYNC by the decoder.
    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_TRACK  = 2'b01,
        ST_FAULT  = 2'b10
    } state_e;

    localparam int GRAY_MAX_W = 32;

    // Bit i of the result is the XOR of g[w-1:i]; bits at or above w are zero.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        b   = {GRAY_MAX_W{1'b0}};
        acc = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end else begin
                b[i] = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decoder_if.sv
// Bundle of the decoder's sample inputs and registered status outputs.
// The source side uses master; the decoder uses slave.
interface gray_decoder_if #(
    parameter int W     = 3,
    parameter int POS_W = 8
);
    logic             enable;
    logic [W-1:0]     g;
    logic             clear_err;
    logic [W-1:0]     bin;
    logic             step;
    logic             dir_up;
    logic [POS_W-1:0] pos;
    logic             err;

    modport master (
        output enable, g, clear_err,
        input  bin, step, dir_up, pos, err
    );

    modport slave (
        input  enable, g, clear_err,
        output bin, step, dir_up, pos, err
    );
endinterface

// File: rtl/gray_decoder_gray_to_bin.sv
// Purely combinational W-bit Gray to binary converter.
// Kept standalone so counter benches can reuse it.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] g_i,
    output logic [W-1:0] b_o
);

    logic [GRAY_MAX_W-1:0] wide_s;

    assign wide_s = gray2bin(GRAY_MAX_W'(g_i), W);
    assign b_o    = wide_s[W-1:0];

endmodule

// File: rtl/gray_decoder.sv
// Gray-coded position receiver: tracks single binary steps, accumulates a
// wrapping signed position and latches a sticky error on non-adjacent jumps.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int W     = 3,
    parameter int POS_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    gray_decoder_if.slave  bus
);

    localparam logic [W-1:0]     ONE_W   = W'(1'b1);
    localparam logic [POS_W-1:0] ONE_POS = POS_W'(1'b1);

    state_e           state_q, state_d;
    logic [W-1:0]     prev_q,  prev_d;
    logic [W-1:0]     bin_q,   bin_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic             dir_q,   dir_d;
    logic             step_q,  step_d;
    logic             err_q,   err_d;

    logic [W-1:0]     nb_s;
    logic [W-1:0]     bin_inc_s;
    logic [W-1:0]     bin_dec_s;
    logic             same_s;
    logic             is_up_s;
    logic             is_dn_s;

    gray_to_bin #(.W(W)) u_g2b (
        .g_i (bus.g),
        .b_o (nb_s)
    );

    // Adjacency is judged on binary values so 1->6 is illegal despite a 1-bit Gray change.
    assign bin_inc_s = bin_q + ONE_W;
    assign bin_dec_s = bin_q - ONE_W;
    assign same_s    = (bus.g == prev_q);
    assign is_up_s   = (nb_s == bin_inc_s);
    assign is_dn_s   = (nb_s == bin_dec_s);

    // Next-state and next-output logic for the UNSYNC/TRACK/FAULT tracker.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_TRACK: begin
                if (bus.enable) begin
                    if (same_s) begin
                        state_d = ST_TRACK;
                    end else if (is_up_s) begin
                        prev_d = bus.g;
                        bin_d  = nb_s;
                        pos_d  = pos_q + ONE_POS;
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                    end else if (is_dn_s) begin
                        prev_d = bus.g;
                        bin_d  = nb_s;
                        pos_d  = pos_q - ONE_POS;
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_FAULT: begin
                // Clear is honoured even with enable low; capture waits for the next enabled edge.
                if (bus.clear_err) begin
                    err_d   = 1'b0;
                    state_d = ST_UNSYNC;
                end else begin
                    err_d   = 1'b1;
                end
            end
            default: begin
                if (bus.enable) begin
                    prev_d  = bus.g;
                    bin_d   = nb_s;
                    state_d = ST_TRACK;
                end else begin
                    state_d = ST_UNSYNC;
                end
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_UNSYNC;
            prev_q  <= {W{1'b0}};
            bin_q   <= {W{1'b0}};
            pos_q   <= {POS_W{1'b0}};
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign bus.bin    = bin_q;
    assign bus.pos    = pos_q;
    assign bus.dir_up = dir_q;
    assign bus.step   = step_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed scenarios plus randomized
// walks compared against a lookup-table reference model.
module tb_gray_decoder;

    localparam int W     = 3;
    localparam int POS_W = 8;
    localparam int NCODE = 8;

    logic clk;
    logic reset;

    gray_decoder_if #(.W(W), .POS_W(POS_W)) bus ();

    gray_decoder #(.W(W), .POS_W(POS_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: 0 = unsynced, 1 = tracking, 2 = faulted.
    int inv_tbl [NCODE];
    int m_mode;
    int m_bin;
    int m_pos;
    int m_dir;
    int m_step;
    int m_err;
    int step_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic mdl_reset();
        m_mode = 0; m_bin = 0; m_pos = 0; m_dir = 0; m_step = 0; m_err = 0;
    endtask

    task automatic mdl_edge(input logic en, input int gv, input logic clr);
        int nb;
        int diff;
        m_step = 0;
        if (m_mode == 2) begin
            if (clr) begin
                m_err  = 0;
                m_mode = 0;
            end
        end else if (en) begin
            nb = inv_tbl[gv];
            if (m_mode == 0) begin
                m_bin  = nb;
                m_mode = 1;
            end else begin
                diff = (nb - m_bin + NCODE) % NCODE;
                if (diff == 1) begin
                    m_bin = nb; m_pos = (m_pos + 1) % 256; m_dir = 1; m_step = 1;
                end else if (diff == NCODE - 1) begin
                    m_bin = nb; m_pos = (m_pos + 255) % 256; m_dir = 0; m_step = 1;
                end else if (diff != 0) begin
                    m_err  = 1;
                    m_mode = 2;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("bin",    32'(bus.bin),    32'(m_bin));
        check("pos",    32'(bus.pos),    32'(m_pos));
        check("step",   32'(bus.step),   32'(m_step));
        check("dir_up", 32'(bus.dir_up), 32'(m_dir));
        check("err",    32'(bus.err),    32'(m_err));
    endtask

    // Drive at the falling edge, let one rising edge occur, compare at the next falling edge.
    task automatic cycle(input logic en, input logic [2:0] gv, input logic clr);
        bus.enable    = en;
        bus.g         = gv;
        bus.clear_err = clr;
        @(posedge clk);
        mdl_edge(en, int'(gv), clr);
        @(negedge clk);
        compare_all();
        if (bus.step === 1'b1) step_cnt++;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        mdl_reset();
        check("rst_bin",  32'(bus.bin),    32'd0);
        check("rst_pos",  32'(bus.pos),    32'd0);
        check("rst_step", 32'(bus.step),   32'd0);
        check("rst_dir",  32'(bus.dir_up), 32'd0);
        check("rst_err",  32'(bus.err),    32'd0);
        #1 reset = 1'b0;
    endtask

    logic [2:0] up_seq [8];
    int         delta;
    int         pick;

    initial begin
        n_checks = 0;
        n_errors = 0;
        step_cnt = 0;
        for (int b = 0; b < NCODE; b++) inv_tbl[gray_of(b)] = b;
        up_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.g         = 3'b000;
        bus.clear_err = 1'b0;
        mdl_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Up count through the full cycle and back to 000.
        cycle(1'b1, 3'b000, 1'b0);
        step_cnt = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, up_seq[i], 1'b0);
        check("up_bin",   32'(bus.bin),    32'd0);
        check("up_pos",   32'(bus.pos),    32'd8);
        check("up_steps", 32'(step_cnt),   32'd8);
        check("up_dir",   32'(bus.dir_up), 32'd1);

        // Down wrap 0 -> 7 from a fresh sync.
        reset_pulse();
        cycle(1'b1, 3'b000, 1'b0);
        step_cnt = 0;
        cycle(1'b1, 3'b100, 1'b0);
        check("dn_bin",  32'(bus.bin),    32'd7);
        check("dn_pos",  32'(bus.pos),    32'hFF);
        check("dn_dir",  32'(bus.dir_up), 32'd0);
        check("dn_step", 32'(step_cnt),   32'd1);

        // Move to 001 then jump 1 -> 6 (single Gray bit flip, illegal).
        cycle(1'b1, 3'b000, 1'b0);
        cycle(1'b1, 3'b001, 1'b0);
        cycle(1'b1, 3'b101, 1'b1);
        check("ill_err", 32'(bus.err), 32'd1);
        check("ill_bin", 32'(bus.bin), 32'd1);
        check("ill_pos", 32'(bus.pos), 32'd1);
        cycle(1'b1, 3'b111, 1'b0);
        cycle(1'b1, 3'b110, 1'b0);
        check("ill_hold", 32'(bus.bin), 32'd1);

        // Recovery: clear with enable, then capture without step, then step.
        cycle(1'b1, 3'b110, 1'b1);
        check("rec_err", 32'(bus.err), 32'd0);
        cycle(1'b1, 3'b110, 1'b0);
        check("rec_bin", 32'(bus.bin),  32'd4);
        check("rec_stp", 32'(bus.step), 32'd0);
        cycle(1'b1, 3'b111, 1'b0);
        check("rec_pos", 32'(bus.pos), 32'd2);

        // Walk 5 -> 6 -> 7 -> 0, then gate enable while g moves.
        cycle(1'b1, 3'b101, 1'b0);
        cycle(1'b1, 3'b100, 1'b0);
        cycle(1'b1, 3'b000, 1'b0);
        cycle(1'b0, 3'b001, 1'b0);
        cycle(1'b0, 3'b011, 1'b0);
        check("gate_bin", 32'(bus.bin), 32'd0);
        check("gate_pos", 32'(bus.pos), 32'd5);
        cycle(1'b1, 3'b011, 1'b0);
        check("gate_err", 32'(bus.err), 32'd1);

        // Clear with enable low, then asynchronous reset mid-cycle at pos 5.
        cycle(1'b0, 3'b011, 1'b1);
        check("mid_pos", 32'(bus.pos), 32'd5);
        reset_pulse();
        cycle(1'b1, 3'b011, 1'b0);
        check("post_bin",  32'(bus.bin),  32'd2);
        check("post_step", 32'(bus.step), 32'd0);

        // Randomized walks: mostly adjacent moves, occasional jumps, gating and clears.
        for (int n = 0; n < 600; n++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 40)      delta = 1;
            else if (pick < 75) delta = NCODE - 1;
            else if (pick < 88) delta = 0;
            else                delta = int'($urandom_range(2, NCODE - 2));
            cycle(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                  3'(gray_of((m_bin + delta) % NCODE)),
                  ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
